// File: rtl/mp_adder_pkg.sv
// mp_adder_seq shared definitions.
// Byte width and sequencer FSM states.
package mp_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mp_adder_seq_if.sv
// Stream and lookahead-unit bundle for mp_adder_seq.
// slave = the sequencer, master = its environment.
interface mp_adder_seq_if;

  logic                            in_valid;
  logic                            in_ready;
  logic [mp_adder_pkg::BYTE_W-1:0] in_a;
  logic [mp_adder_pkg::BYTE_W-1:0] in_b;
  logic                            in_first;
  logic                            in_last;
  logic                            in_sub;
  logic [mp_adder_pkg::BYTE_W-1:0] cla_p;
  logic [mp_adder_pkg::BYTE_W-1:0] cla_g;
  logic                            cla_c_in;
  logic [mp_adder_pkg::BYTE_W:0]   cla_c_out;
  logic                            out_valid;
  logic                            out_ready;
  logic [mp_adder_pkg::BYTE_W-1:0] out_sum;
  logic                            out_last;
  logic                            out_carry;
  logic                            out_ovf;
  logic                            err;

  modport slave (
    input  in_valid, in_a, in_b,
    input  in_first, in_last, in_sub,
    input  cla_c_out, out_ready,
    output in_ready, cla_p, cla_g, cla_c_in,
    output out_valid, out_sum, out_last,
    output out_carry, out_ovf, err
  );

  modport master (
    output in_valid, in_a, in_b,
    output in_first, in_last, in_sub,
    output cla_c_out, out_ready,
    input  in_ready, cla_p, cla_g, cla_c_in,
    input  out_valid, out_sum, out_last,
    input  out_carry, out_ovf, err
  );

endinterface

// File: rtl/mp_adder_seq_pg_gen.sv
// Propagate/generate terms for one byte.
// inv_b turns the adder into a subtractor.
module pg_gen
  import mp_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              inv_b,
  output logic [BYTE_W-1:0] p,
  output logic [BYTE_W-1:0] g
);

  logic [BYTE_W-1:0] b_eff;

  // effective B operand and its p/g terms
  always_comb begin
    b_eff = inv_b ? ~b : b;
    p     = a ^ b_eff;
    g     = a & b_eff;
  end

endmodule

// File: rtl/mp_adder_seq.sv
// Multi-precision byte-serial add/sub sequencer.
// Subtraction enabled by MP_ADDER_SUB_EN.
module mp_adder_seq
  import mp_adder_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  mp_adder_seq_if.slave bus
);

  state_t state;
  state_t state_nx;

  logic              acc;
  logic              adv;
  logic              in_rdy;
  logic              eff_first;
  logic              proto_err;

  logic              s0_valid;
  logic [BYTE_W-1:0] s0_a;
  logic [BYTE_W-1:0] s0_b;
  logic              s0_first;
  logic              s0_last;
  logic              sub_q;
  logic              carry_q;

  logic              o_valid;
  logic [BYTE_W-1:0] o_sum;
  logic              o_last;
  logic              o_carry;
  logic              o_ovf;
  logic              err_q;

  logic [BYTE_W-1:0] p;
  logic [BYTE_W-1:0] g;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next state: track word boundaries
  always_comb begin
    state_nx = state;
    if (acc) begin
      unique case (state)
        ST_IDLE: state_nx = bus.in_last ? ST_IDLE : ST_RUN;
        ST_RUN:  state_nx = bus.in_last ? ST_IDLE : ST_RUN;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: handshake and protocol check
  always_comb begin
    in_rdy    = !s0_valid | !o_valid | bus.out_ready;
    acc       = bus.in_valid & in_rdy;
    adv       = s0_valid & (!o_valid | bus.out_ready);
    eff_first = 1'b0;
    proto_err = 1'b0;
    unique case (state)
      ST_IDLE: begin
        eff_first = 1'b1;
        proto_err = acc & !bus.in_first;
      end
      ST_RUN: begin
        eff_first = bus.in_first;
        proto_err = acc & bus.in_first;
      end
      default: begin
        eff_first = 1'b1;
        proto_err = 1'b0;
      end
    endcase
  end

`ifdef MP_ADDER_SUB_EN
  // operation mode, sampled with each word's first byte
  always_ff @(posedge clk) begin
    if (!rst_n)                sub_q <= 1'b0;
    else if (acc && eff_first) sub_q <= bus.in_sub;
  end
`else
  logic sub_unused;
  assign sub_unused = bus.in_sub;
  assign sub_q      = 1'b0;
`endif

  // stage 0 operand register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_first <= 1'b0;
      s0_last  <= 1'b0;
    end else begin
      s0_valid <= acc | (s0_valid & !adv);
      if (acc) begin
        s0_a     <= bus.in_a;
        s0_b     <= bus.in_b;
        s0_first <= eff_first;
        s0_last  <= bus.in_last;
      end
    end
  end

  pg_gen u_pg (
    .a     (s0_a),
    .b     (s0_b),
    .inv_b (sub_q),
    .p     (p),
    .g     (g)
  );

  // stage 1 result register and byte carry chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_last  <= 1'b0;
      o_carry <= 1'b0;
      o_ovf   <= 1'b0;
      carry_q <= 1'b0;
    end else if (adv) begin
      o_valid <= 1'b1;
      o_sum   <= p ^ bus.cla_c_out[BYTE_W-1:0];
      o_last  <= s0_last;
      o_carry <= bus.cla_c_out[BYTE_W];
      o_ovf   <= bus.cla_c_out[BYTE_W]
               ^ bus.cla_c_out[BYTE_W-1];
      carry_q <= bus.cla_c_out[BYTE_W];
    end else if (bus.out_ready) begin
      o_valid <= 1'b0;
    end
  end

  // sticky protocol error
  always_ff @(posedge clk) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (proto_err) err_q <= 1'b1;
  end

  assign bus.in_ready  = in_rdy;
  assign bus.cla_p     = p;
  assign bus.cla_g     = g;
  assign bus.cla_c_in  = s0_first ? sub_q : carry_q;
  assign bus.out_valid = o_valid;
  assign bus.out_sum   = o_sum;
  assign bus.out_last  = o_last;
  assign bus.out_carry = o_carry;
  assign bus.out_ovf   = o_ovf;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mp_adder_seq.sv
// Self-checking bench for mp_adder_seq with a
// behavioural cla_8bit and word-level reference model.
module tb_mp_adder_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mp_adder_seq_if bus ();

  mp_adder_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // lookahead unit: carries recovered from p + 2g + c_in
  logic [8:0] cla_s;
  assign cla_s = {1'b0, bus.cla_p} + {bus.cla_g, 1'b0}
               + {8'd0, bus.cla_c_in};
  assign bus.cla_c_out = {cla_s[8], cla_s[7:0] ^ bus.cla_p};

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    logic       last;
  } exp_t;

  exp_t       mq[$];
  logic [7:0] got[$];
  logic       gotc[$];
  logic       m_err, m_inword, m_carry, m_sub;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model and per-cycle comparison
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_err = 0; m_inword = 0; m_carry = 0; m_sub = 0;
    end else begin
      chk("err", {31'd0, bus.err}, {31'd0, m_err});
      if (bus.out_valid) begin
        if (mq.size() == 0) begin
          chk("spurious_out", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          chk("sum", {24'd0, bus.out_sum}, {24'd0, mq[0].sum});
          chk("carry", {31'd0, bus.out_carry}, {31'd0, mq[0].carry});
          chk("last", {31'd0, bus.out_last}, {31'd0, mq[0].last});
          if (mq[0].last)
            chk("ovf", {31'd0, bus.out_ovf}, {31'd0, mq[0].ovf});
          if (bus.out_ready) begin
            void'(mq.pop_front());
            got.push_back(bus.out_sum);
            gotc.push_back(bus.out_carry);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        logic       ef, cin;
        logic [7:0] bb;
        logic [8:0] s;
        exp_t       e;
        ef = bus.in_first | !m_inword;
        if ((!m_inword && !bus.in_first) || (m_inword && bus.in_first))
          m_err = 1;
`ifdef MP_ADDER_SUB_EN
        if (ef) m_sub = bus.in_sub;
`else
        m_sub = 0;
`endif
        bb = m_sub ? ~bus.in_b : bus.in_b;
        cin = ef ? m_sub : m_carry;
        s = {1'b0, bus.in_a} + {1'b0, bb} + {8'd0, cin};
        e.sum = s[7:0];
        e.carry = s[8];
        e.ovf = (bus.in_a[7] == bb[7]) && (s[7] != bus.in_a[7]);
        e.last = bus.in_last;
        mq.push_back(e);
        m_carry = s[8];
        m_inword = !bus.in_last;
      end
    end
  end

  // offer one byte; starts and ends just after a rising edge
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic f, input logic l, input logic s);
    logic acc;
    int   k;
    acc = 0;
    k = 0;
    bus.in_valid = 1; bus.in_a = a; bus.in_b = b;
    bus.in_first = f; bus.in_last = l; bus.in_sub = s;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      k++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk); #1;
      if (mq.size() == 0 && !bus.out_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
    bus.in_first = 0; bus.in_last = 0; bus.in_sub = 0;
    bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_p", {24'd0, bus.cla_p}, 32'd0);
    chk("rst_g", {24'd0, bus.cla_g}, 32'd0);
    chk("rst_cin", {31'd0, bus.cla_c_in}, 32'd0);

    // single byte 7F + 01
    send(8'h7F, 8'h01, 1, 1, 0);
    chk("lat_early", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_sum", {24'd0, bus.out_sum}, 32'h80);
    chk("t1_carry", {31'd0, bus.out_carry}, 32'd0);
    chk("t1_ovf", {31'd0, bus.out_ovf}, 32'd1);
    drain();

    // 0x01FF + 0x0001
    got.delete(); gotc.delete();
    send(8'hFF, 8'h01, 1, 0, 0);
    send(8'h01, 8'h00, 0, 1, 0);
    drain();
    chk("t2_n", got.size(), 32'd2);
    if (got.size() == 2) begin
      chk("t2_s0", {24'd0, got[0]}, 32'h00);
      chk("t2_c0", {31'd0, gotc[0]}, 32'd1);
      chk("t2_s1", {24'd0, got[1]}, 32'h02);
      chk("t2_c1", {31'd0, gotc[1]}, 32'd0);
    end

    // 0x0100 - 0x0001
    got.delete(); gotc.delete();
    send(8'h00, 8'h01, 1, 0, 1);
    send(8'h01, 8'h00, 0, 1, 0);
    drain();
    chk("t3_n", got.size(), 32'd2);
    if (got.size() == 2) begin
`ifdef MP_ADDER_SUB_EN
      chk("t3_s0", {24'd0, got[0]}, 32'hFF);
      chk("t3_s1", {24'd0, got[1]}, 32'h00);
      chk("t3_c1", {31'd0, gotc[1]}, 32'd1);
`else
      chk("t3_s0", {24'd0, got[0]}, 32'h01);
      chk("t3_s1", {24'd0, got[1]}, 32'h01);
      chk("t3_c1", {31'd0, gotc[1]}, 32'd0);
`endif
    end

    // 4-byte stream with downstream stalled 3 cycles
    got.delete(); gotc.delete();
    bus.out_ready = 0;
    fork
      begin
        send(8'h10, 8'h01, 1, 0, 0);
        send(8'h20, 8'h02, 0, 0, 0);
        send(8'h30, 8'h03, 0, 0, 0);
        send(8'h40, 8'h04, 0, 1, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_sum", {24'd0, bus.out_sum}, 32'h11);
        @(posedge clk); #1;
        chk("stall_hold", {24'd0, bus.out_sum}, 32'h11);
        bus.out_ready = 1;
      end
    join
    drain();
    chk("t4_n", got.size(), 32'd4);
    if (got.size() == 4) begin
      chk("t4_s0", {24'd0, got[0]}, 32'h11);
      chk("t4_s1", {24'd0, got[1]}, 32'h22);
      chk("t4_s2", {24'd0, got[2]}, 32'h33);
      chk("t4_s3", {24'd0, got[3]}, 32'h44);
    end

    // restart mid-word, then non-first byte in IDLE
    got.delete(); gotc.delete();
    chk("t5_err_pre", {31'd0, bus.err}, 32'd0);
    send(8'h01, 8'h01, 1, 0, 0);
    send(8'h05, 8'h05, 1, 0, 1);
    send(8'h00, 8'h00, 0, 1, 0);
    send(8'h03, 8'h04, 0, 1, 0);
    drain();
    chk("t5_err", {31'd0, bus.err}, 32'd1);
    chk("t5_n", got.size(), 32'd4);
    if (got.size() == 4) begin
      chk("t5_s0", {24'd0, got[0]}, 32'h02);
`ifdef MP_ADDER_SUB_EN
      chk("t5_s1", {24'd0, got[1]}, 32'h00);
      chk("t5_c1", {31'd0, gotc[1]}, 32'd1);
`else
      chk("t5_s1", {24'd0, got[1]}, 32'h0A);
      chk("t5_c1", {31'd0, gotc[1]}, 32'd0);
`endif
      chk("t5_s3", {24'd0, got[3]}, 32'h07);
    end

    // reset mid-word
    got.delete(); gotc.delete();
    send(8'hFF, 8'hFF, 1, 0, 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_err", {31'd0, bus.err}, 32'd0);
    chk("t6_cin", {31'd0, bus.cla_c_in}, 32'd0);
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send(8'h01, 8'h01, 1, 1, 0);
    drain();
    chk("t6_n", got.size(), 32'd1);
    if (got.size() == 1) begin
      chk("t6_s0", {24'd0, got[0]}, 32'h02);
      chk("t6_c0", {31'd0, gotc[0]}, 32'd0);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_adder_seq.md
# mp_adder_seq

Multi-precision adder sequencer wrapped around `cla_8bit`. It accepts operand bytes least-significant first over a valid/ready stream and generates `p`/`g` and `c_in` for the lookahead unit. It consumes `c_out[8:0]` to form sum bytes and chains the byte carry into the next byte of the same word. It sits directly upstream and downstream of `cla_8bit` in the ALU datapath.

## Interface
Parameters:
- none; byte width is fixed at 8 and shared via the package.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operand byte offered
- `in_ready`  out  1  operand byte accepted when `in_valid & in_ready`
- `in_a`  in  8  operand A byte
- `in_b`  in  8  operand B byte
- `in_first`  in  1  byte is least significant of a new word
- `in_last`  in  1  byte is most significant of the word
- `in_sub`  in  1  word is A−B; sampled with the first byte
- `cla_p`  out  8  propagate to `cla_8bit.p`
- `cla_g`  out  8  generate to `cla_8bit.g`
- `cla_c_in`  out  1  carry-in to `cla_8bit.c_in`
- `cla_c_out`  in  9  carries from `cla_8bit.c_out`
- `out_valid`  out  1  sum byte available
- `out_ready`  in  1  downstream accepts sum byte
- `out_sum`  out  8  sum byte
- `out_last`  out  1  byte is the word's MSB
- `out_carry`  out  1  `cla_c_out[8]` of this byte
- `out_ovf`  out  1  signed overflow; meaningful only with `out_last`
- `err`  out  1  sticky protocol error

## Operation
- Stage 0: an accepted byte loads the operand register `s0_a`, `s0_b`, `s0_first`, `s0_last`, and sets `s0_valid`.
  - `in_sub` is latched into `sub_q` only on a first byte.
- `b_eff = sub_q ? ~s0_b : s0_b`.
- `cla_p = s0_a ^ b_eff` and `cla_g = s0_a & b_eff`; both come from registers, with no input-to-output combinational path.
- `cla_c_in = s0_first ? sub_q : carry_q`.
- Stage 1 loads on advance:
  - `out_sum = cla_p ^ cla_c_out[7:0]`
  - `out_carry = cla_c_out[8]`
  - `out_ovf = cla_c_out[8] ^ cla_c_out[7]`
  - `out_last = s0_last`
  - `carry_q <= cla_c_out[8]`
- FSM states:
  - IDLE: expects a first byte.
  - RUN: mid-word.
- Transitions:
  - IDLE→RUN on an accepted non-last byte.
  - RUN→IDLE on an accepted last byte.
  - A first+last byte stays in IDLE (single-byte word).
- Protocol violations:
  - A byte with `in_first=0` accepted in IDLE is treated as first; `err` is set.
  - A byte with `in_first=1` accepted in RUN restarts the word, `sub_q` is re-sampled, and `err` is set.
- `err` clears only on reset.
- Arithmetic is modulo 2^8 per byte. The word result is the concatenation of `out_sum` bytes. The final `out_carry` is the carry out of the word (for subtraction, 1 means no borrow).

## Timing
- Reset (`rst_n=0` at an edge) sets every register to 0: `s0_valid`, `out_valid`, `out_sum`, `out_last`, `out_carry`, `out_ovf`, `err`, `carry_q`, `sub_q`; the FSM goes to IDLE.
- Outputs after that edge:
  - `in_ready=1`
  - `cla_p=cla_g=0`, `cla_c_in=0`
- Reset mid-word discards all in-flight bytes with no partial output.
- Latency: a byte accepted at edge N appears with `out_valid=1` after edge N+1.
- Throughput is 1 byte/clock.
- Stage 1 advances when `s0_valid & (!out_valid | out_ready)`.
- `in_ready = !s0_valid | !out_valid | out_ready`, so bubble-free back-to-back transfer is possible.
- Output handshake:
  - `out_valid` stays high with all out fields stable until `out_ready`.
  - `carry_q` updates only on a stage-1 advance.
- Simultaneous output drain and input accept in the same cycle is legal and required.

## Configuration
- `MP_ADDER_SUB_EN` defined: subtraction is supported as described.
- Not defined: the `in_sub` port still exists but is ignored, `sub_q` is tied to 0, and `b_eff = s0_b`.

## Structure
- `mp_adder_pkg` holds:
  - `BYTE_W = 8`
  - the FSM state enum (`ST_IDLE`, `ST_RUN`)
- Sub-module `pg_gen`: combinational `p`/`g` from `a`, `b`, `inv_b`.
- `cla_8bit` is instantiated by the parent ALU, not inside this block.

## Test plan
- Single byte `a=0x7F`, `b=0x01`, `first=last=1`, `sub=0` → `out_sum=0x80`, `out_carry=0`, `out_ovf=1`, output one cycle after accept.
- Two-byte `0x01FF+0x0001` (bytes FF/01, then 01/00) → sums `0x00` then `0x02`; last byte `out_carry=0`; first byte `out_carry=1`.
- Sub word `0x0100−0x0001`, `sub=1` → sums `0xFF` then `0x00`, final `out_carry=1`; with `MP_ADDER_SUB_EN` undefined → sums `0x01` then `0x01`.
- `out_ready=0` for 3 cycles during a 4-byte stream → `in_ready` drops after stage 0 fills; no byte lost or duplicated; `out_sum` held stable.
- Second `first` byte mid-word, then a non-first byte in IDLE → `err=1` and word restarted with `c_in=sub`.
- Reset asserted mid-word → next-edge `out_valid=0`, `err=0`, `carry_q=0`; the following word computes with `c_in` from its own first byte.
